// File: rtl/pcie_rx_tlp_buffer.sv
// ---------------------------------------------------------------------------
// pcie_rx_tlp_buffer
//
// Purpose:
//   Receive-side TLP buffer for the PCIe Transaction Layer.
//   - Entries from the Data Link Layer are accepted without backpressure,
//     because the link is credit-based.
//   - Entries are held in a circular buffer and presented to the TL consumer
//     through a valid/ready handshake.
//   - Freed entries are returned to the link partner as cumulative header
//     credits. Each return is an UpdateFC request with a request/ack
//     handshake.
//
// Optional build macro:
//   PCIE_RX_FC_TIMER_EN - adds an idle timer that forces an UpdateFC when a
//   small number of freed credits sits unreported for FC_TIMER_CYCLES cycles.
//   Without it, only the FC_UPDATE_THRESH threshold triggers updates.
//   The ports are identical in both builds.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   rx_valid_i      DLL delivers one entry this cycle
//   rx_data_i       entry payload
//   tlp_valid_o     buffer non-empty
//   tlp_data_o      head entry (zero while empty)
//   tlp_ready_i     consumer accepts the head entry
//   count_o         current occupancy
//   overflow_o      sticky credit-violation flag (cleared only by reset)
//   fc_update_o     UpdateFC request
//   fc_allocated_o  cumulative credits allocated, mod 256
//   fc_update_ack_i DLL has consumed the request
// ---------------------------------------------------------------------------
module pcie_rx_tlp_buffer #(
  parameter int DEPTH_LG2        = 4,
  parameter int DATA_WIDTH       = 224,
  parameter int FC_UPDATE_THRESH = 4,
  parameter int FC_TIMER_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  tlp_valid_o,
  output logic [DATA_WIDTH-1:0] tlp_data_o,
  input  logic                  tlp_ready_i,
  output logic [DEPTH_LG2:0]    count_o,
  output logic                  overflow_o,
  output logic                  fc_update_o,
  output logic [7:0]            fc_allocated_o,
  input  logic                  fc_update_ack_i
);

  localparam int FIFO_DEPTH = 1 << DEPTH_LG2;
  localparam int PW         = DEPTH_LG2 + 1;
  localparam logic [PW-1:0] THRESH_W = PW'(FC_UPDATE_THRESH);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REQ} fc_state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wrptr, r_rdptr;
  logic [PW-1:0]         w_wrptr_next, w_rdptr_next;
  logic                  r_full, r_empty, r_overflow;
  logic                  w_push, w_drop, w_pop;

  fc_state_t             r_state, w_state_next;
  logic [7:0]            r_alloc;
  logic [PW-1:0]         r_freed;
  logic                  w_fc_update, w_fc_trigger, w_timer_hit;

  // A simultaneous pop never rescues a push: full is the value registered at
  // the start of the cycle.
  assign w_push       = rx_valid_i & ~r_full;
  assign w_drop       = rx_valid_i & r_full;
  assign w_pop        = ~r_empty & tlp_ready_i;
  assign w_wrptr_next = r_wrptr + PW'(w_push);
  assign w_rdptr_next = r_rdptr + PW'(w_pop);

  // Storage is not reset; reset only discards the contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrptr[DEPTH_LG2-1:0]] <= rx_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wrptr    <= w_wrptr_next;
      r_rdptr    <= w_rdptr_next;
      r_empty    <= (w_wrptr_next == w_rdptr_next);
      r_full     <= (w_wrptr_next[PW-1] != w_rdptr_next[PW-1]) &&
                    (w_wrptr_next[PW-2:0] == w_rdptr_next[PW-2:0]);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign tlp_valid_o = ~r_empty;
  // Masked while empty so that stale or uninitialised storage never shows.
  assign tlp_data_o  = r_empty ? '0 : r_mem[r_rdptr[DEPTH_LG2-1:0]];
  assign count_o     = r_wrptr - r_rdptr;
  assign overflow_o  = r_overflow;

`ifdef PCIE_RX_FC_TIMER_EN
  // The timer runs only while a few credits are pending below the threshold.
  // It is cleared on a hit so that it restarts from zero after the next
  // return to IDLE.
  localparam logic [15:0] TIMER_LAST = 16'(FC_TIMER_CYCLES - 1);
  logic [15:0] r_timer;
  logic        w_timer_run;

  assign w_timer_run = (r_state == ST_IDLE) && (r_freed != '0) && (r_freed < THRESH_W);
  assign w_timer_hit = w_timer_run && (r_timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_timer_run && !w_timer_hit) begin
      r_timer <= r_timer + 16'd1;
    end else begin
      r_timer <= '0;
    end
  end
`else
  // No timer in this build. FC_TIMER_CYCLES only matters when the timer is
  // enabled, and this comparison is always false.
  assign w_timer_hit = (FC_TIMER_CYCLES < 0);
`endif

  assign w_fc_trigger = (r_state == ST_IDLE) && ((r_freed >= THRESH_W) || w_timer_hit);

  always_comb begin
    w_state_next = r_state;
    w_fc_update  = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_fc_update = 1'b1;
        if (fc_update_ack_i) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_fc_trigger) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        w_fc_update = 1'b1;
        if (fc_update_ack_i) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_alloc <= 8'(FIFO_DEPTH);
      r_freed <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fc_trigger) begin
        // The credits are handed off here. A pop in the same cycle starts
        // the next batch.
        r_alloc <= r_alloc + 8'(r_freed);
        r_freed <= PW'(w_pop);
      end else begin
        r_freed <= r_freed + PW'(w_pop);
      end
    end
  end

  assign fc_update_o    = w_fc_update;
  assign fc_allocated_o = r_alloc;

endmodule

// File: tb/tb_pcie_rx_tlp_buffer.sv
// ---------------------------------------------------------------------------
// tb_pcie_rx_tlp_buffer
//
// Directed testbench for pcie_rx_tlp_buffer with default parameters.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at the same point.
// The timer scenario follows PCIE_RX_FC_TIMER_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_pcie_rx_tlp_buffer;

  localparam int DW = 224;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid_i = 1'b0;
  logic [DW-1:0] rx_data_i = '0;
  logic          tlp_valid_o;
  logic [DW-1:0] tlp_data_o;
  logic          tlp_ready_i = 1'b0;
  logic [4:0]    count_o;
  logic          overflow_o;
  logic          fc_update_o;
  logic [7:0]    fc_allocated_o;
  logic          fc_update_ack_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_alloc;
  logic [DW-1:0] exp_q [$];

  pcie_rx_tlp_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_valid_i      (rx_valid_i),
    .rx_data_i       (rx_data_i),
    .tlp_valid_o     (tlp_valid_o),
    .tlp_data_o      (tlp_data_o),
    .tlp_ready_i     (tlp_ready_i),
    .count_o         (count_o),
    .overflow_o      (overflow_o),
    .fc_update_o     (fc_update_o),
    .fc_allocated_o  (fc_allocated_o),
    .fc_update_ack_i (fc_update_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick();
    rx_valid_i = 1'b0;
    $display("push data=%0h count=%0d", d, count_o);
  endtask

  task automatic pop_one(input logic [DW-1:0] exp_d);
    check("pop_valid", 256'(tlp_valid_o), 256'(1'b1));
    check("pop_data", 256'(tlp_data_o), 256'(exp_d));
    tlp_ready_i = 1'b1;
    tick();
    tlp_ready_i = 1'b0;
    $display("pop  data=%0h count=%0d", exp_d, count_o);
  endtask

  task automatic ack_one();
    fc_update_ack_i = 1'b1;
    tick();
    fc_update_ack_i = 1'b0;
    check("ack_drops_req", 256'(fc_update_o), 256'(1'b0));
  endtask

  // Reset is asserted off the clock edge; the outputs must react without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 256'(tlp_valid_o), 256'(1'b0));
    check("rst_data", 256'(tlp_data_o), 256'(0));
    check("rst_count", 256'(count_o), 256'(0));
    check("rst_overflow", 256'(overflow_o), 256'(1'b0));
    check("rst_fc_update", 256'(fc_update_o), 256'(1'b1));
    check("rst_alloc", 256'(fc_allocated_o), 256'(8'd16));
    tick();
    rst_n = 1'b1;
    tick();
    check("init_fc_update", 256'(fc_update_o), 256'(1'b1));
    ack_one();
    exp_alloc = 8'd16;
  endtask

  initial begin
    // 1: reset and the initial advertisement
    tick();
    do_reset();
    // Acks are ignored in IDLE.
    fc_update_ack_i = 1'b1;
    tick();
    fc_update_ack_i = 1'b0;
    tick();
    check("idle_ack_ignored", 256'(fc_update_o), 256'(1'b0));

    // 2: fill to full, overflow, then drain in order
    push_one(DW'(1));
    check("latency_valid", 256'(tlp_valid_o), 256'(1'b1));
    check("latency_data", 256'(tlp_data_o), 256'(1));
    for (int i = 2; i <= 16; i++) push_one(DW'(i));
    check("full_count", 256'(count_o), 256'(16));
    check("no_overflow_yet", 256'(overflow_o), 256'(1'b0));
    push_one(DW'(32'h11));
    check("overflow_set", 256'(overflow_o), 256'(1'b1));
    check("overflow_count", 256'(count_o), 256'(16));
    for (int i = 1; i <= 16; i++) pop_one(DW'(i));
    check("drained_count", 256'(count_o), 256'(0));
    check("drained_valid", 256'(tlp_valid_o), 256'(1'b0));
    check("overflow_sticky", 256'(overflow_o), 256'(1'b1));
    // The 5th pop saw freed=4 and raised a request; no ack has been given.
    check("drain_req", 256'(fc_update_o), 256'(1'b1));
    check("drain_alloc", 256'(fc_allocated_o), 256'(8'd20));

    // 3: threshold update, hold while un-acked, carry-over of freed credits
    do_reset();
    for (int i = 0; i < 4; i++) push_one(DW'(32'h30 + i));
    for (int i = 0; i < 4; i++) pop_one(DW'(32'h30 + i));
    check("thr_not_yet", 256'(fc_update_o), 256'(1'b0));
    tick();
    check("thr_req", 256'(fc_update_o), 256'(1'b1));
    check("thr_alloc", 256'(fc_allocated_o), 256'(8'd20));
    push_one(DW'(32'h40));
    push_one(DW'(32'h41));
    pop_one(DW'(32'h40));
    pop_one(DW'(32'h41));
    for (int i = 0; i < 6; i++) tick();
    check("hold_req", 256'(fc_update_o), 256'(1'b1));
    check("hold_alloc", 256'(fc_allocated_o), 256'(8'd20));
    ack_one();
    // freed_cnt is 2; two more pops reach the threshold.
    push_one(DW'(32'h42));
    push_one(DW'(32'h43));
    pop_one(DW'(32'h42));
    pop_one(DW'(32'h43));
    check("carry_not_yet", 256'(fc_update_o), 256'(1'b0));
    tick();
    check("carry_req", 256'(fc_update_o), 256'(1'b1));
    check("carry_alloc", 256'(fc_allocated_o), 256'(8'd24));
    ack_one();

    // 4: stall stability, then steady concurrent push/pop at count 8
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      push_one(DW'(32'hA1 + i));
      exp_q.push_back(DW'(32'hA1 + i));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", 256'(tlp_data_o), 256'(DW'(32'hA1)));
    end
    for (int i = 0; i < 5; i++) begin
      push_one(DW'(32'hB1 + i));
      exp_q.push_back(DW'(32'hB1 + i));
    end
    check("count8", 256'(count_o), 256'(8));
    for (int i = 0; i < 20; i++) begin
      check("conc_data", 256'(tlp_data_o), 256'(exp_q.pop_front()));
      rx_valid_i  = 1'b1;
      rx_data_i   = DW'(32'hC00 + i);
      tlp_ready_i = 1'b1;
      exp_q.push_back(DW'(32'hC00 + i));
      tick();
      $display("push+pop data=%0h count=%0d", DW'(32'hC00 + i), count_o);
      check("conc_count", 256'(count_o), 256'(8));
    end
    rx_valid_i  = 1'b0;
    tlp_ready_i = 1'b0;

    // 5: 256 pops with prompt acks; allocation wraps mod 256
    do_reset();
    for (int r = 0; r < 64; r++) begin
      for (int i = 0; i < 4; i++) push_one(DW'(r * 4 + i));
      for (int i = 0; i < 4; i++) pop_one(DW'(r * 4 + i));
      tick();
      exp_alloc = exp_alloc + 8'd4;
      check("wrap_req", 256'(fc_update_o), 256'(1'b1));
      check("wrap_alloc", 256'(fc_allocated_o), 256'(exp_alloc));
      ack_one();
    end
    check("wrap_no_overflow", 256'(overflow_o), 256'(1'b0));

    // 6: single freed credit; only the optional timer reports it
    do_reset();
    push_one(DW'(32'h77));
    pop_one(DW'(32'h77));
`ifdef PCIE_RX_FC_TIMER_EN
    for (int i = 0; i < 63; i++) tick();
    check("timer_not_yet", 256'(fc_update_o), 256'(1'b0));
    tick();
    check("timer_req", 256'(fc_update_o), 256'(1'b1));
    check("timer_alloc", 256'(fc_allocated_o), 256'(8'd17));
`else
    for (int i = 0; i < 100; i++) tick();
    check("no_timer_req", 256'(fc_update_o), 256'(1'b0));
    check("no_timer_alloc", 256'(fc_allocated_o), 256'(8'd16));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_rx_tlp_buffer.md
Name: pcie_rx_tlp_buffer

Overview:
Receive-side TLP buffer for the PCIe Transaction Layer. It is the RX counterpart of the TX TL FIFO.
- Accepts TLP entries from the Data Link Layer with no backpressure, because the link is credit-based.
- Stores them in a circular buffer and presents them to the RX TL consumer via valid/ready.
- Returns freed buffer space to the link partner as cumulative header flow-control credits (UpdateFC requests) through a request/ack handshake.

Parameters:
- DEPTH_LG2, 4, log2 of entry count; FIFO_DEPTH = 2^DEPTH_LG2 (range 2..7).
- DATA_WIDTH, 224, bits per TLP entry.
- FC_UPDATE_THRESH, 4, freed-entry count that triggers an UpdateFC request (1..FIFO_DEPTH).
- FC_TIMER_CYCLES, 64, idle cycles before a forced update; used only with PCIE_RX_FC_TIMER_EN (2..65535).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_valid_i  in  1  DLL delivers one entry this cycle.
- rx_data_i  in  DATA_WIDTH  entry payload.
- tlp_valid_o  out  1  buffer non-empty.
- tlp_data_o  out  DATA_WIDTH  head entry.
- tlp_ready_i  in  1  consumer accepts the head entry.
- count_o  out  DEPTH_LG2+1  current occupancy.
- overflow_o  out  1  sticky credit-violation flag.
- fc_update_o  out  1  UpdateFC request.
- fc_allocated_o  out  8  cumulative credits allocated (mod 256).
- fc_update_ack_i  in  1  DLL has consumed the request.

Behaviour:
- Reset values:
  - buffer empty; wrptr = rdptr = 0 (DEPTH_LG2+1 bits, MSB is the wrap bit).
  - tlp_valid_o = 0, tlp_data_o = 0, count_o = 0, overflow_o = 0.
  - FSM = INIT, fc_update_o = 1, fc_allocated_o = FIFO_DEPTH[7:0].
  - freed_cnt = 0, timer = 0.
- Registered flags:
  - full = wrap bits differ and index bits equal.
  - empty = pointers equal.
  - tlp_valid_o = !empty. count_o = wrptr - rdptr.
- Push: rx_valid_i & !full (full as registered at cycle start). Entry is written at wrptr; wrptr increments.
- Push while full: entry dropped, pointers unchanged, overflow_o <= 1. overflow_o clears only on reset.
- A pop in the same cycle does not rescue a push while full.
- Pop: tlp_valid_o & tlp_ready_i. rdptr increments; the next entry appears the following cycle.
- tlp_data_o = mem[rdptr index] and is stable while tlp_valid_o & !tlp_ready_i.
- Latency: a push in cycle N gives tlp_valid_o = 1 in cycle N+1 if the buffer was empty.
- Simultaneous push and pop when not full and not empty: both occur, count unchanged.
- Pointer wrap-around is natural modulo 2^(DEPTH_LG2+1).
- freed_cnt (DEPTH_LG2+1 bits) increments on every pop in every state, except as noted under IDLE->REQ below.
- FSM:
  - INIT: fc_update_o = 1 (initial advertisement). On fc_update_ack_i -> IDLE.
  - IDLE: fc_update_o = 0. When freed_cnt >= FC_UPDATE_THRESH -> REQ, with these updates in the same edge:
    - fc_allocated_o <= fc_allocated_o + freed_cnt (8-bit wrap).
    - freed_cnt <= 1 if a pop occurs this cycle, else 0.
  - REQ: fc_update_o = 1. fc_allocated_o is held constant. On fc_update_ack_i -> IDLE.
  - The earliest re-request is one cycle after returning to IDLE.
- fc_update_ack_i is ignored in IDLE.
- fc_allocated_o changes only on the IDLE->REQ edge.
- Asynchronous reset mid-operation: all buffered entries and the pending request are discarded, and the block returns to the reset values above.

Optional Feature:
PCIE_RX_FC_TIMER_EN
- Defined:
  - A 16-bit timer counts in IDLE while 0 < freed_cnt < FC_UPDATE_THRESH.
  - The timer clears when freed_cnt = 0 or when the FSM is outside IDLE.
  - When timer = FC_TIMER_CYCLES-1 the FSM takes IDLE->REQ with the same updates as a threshold trigger.
- Undefined:
  - No timer logic; only the threshold triggers updates.
  - Ports are identical in both builds.

Test Plan:
1. Release reset (defaults) -> fc_update_o = 1 and fc_allocated_o = 16. Ack for 1 cycle -> fc_update_o = 0 next cycle.
2. Push 16 entries 0x1..0x10, no pops -> count_o = 16. 17th push 0x11 -> overflow_o = 1, dropped. Drain -> 0x1..0x10 in order, count_o = 0, tlp_valid_o = 0.
3. Push 4, then pop 4 back-to-back -> fc_update_o = 1 one cycle after the 4th pop with fc_allocated_o = 20. Hold ack low 10 cycles while popping 2 more -> value stays 20. Ack -> IDLE with freed_cnt = 2.
4. Hold tlp_ready_i = 0 for 5 cycles with 3 entries queued -> tlp_data_o constant. Concurrent push/pop at count 8 for 20 cycles -> count_o stays 8.
5. Perform 256 pops, acking each update promptly -> fc_allocated_o wraps 0xFC -> 0x00 -> 0x04 correctly, with no overflow.
6. With PCIE_RX_FC_TIMER_EN: after the init ack, push and pop 1 entry -> fc_update_o rises 64 cycles later with fc_allocated_o = 17. Without the macro -> no update.
